i2s_tx_dsp_unpack: RTL

I2S_TX_DSP_UNPACK -- requirements
Module: i2s_tx_dsp_unpack

---
 rtl/i2s_tx_dsp_unpack_if.sv | 19 +
 rtl/i2s_tx_dsp_unpack.sv | 93 +++++++++
 2 files changed

// File: rtl/i2s_tx_dsp_unpack_if.sv
// Word/sample stream bundle between the uDMA TX channel, the unpacker and the DSP channel.
interface i2s_tx_dsp_unpack_if;
    logic [31:0] data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [31:0] fifo_data_o;
    logic        fifo_data_valid_o;
    logic        fifo_data_ready_i;

    modport slave (
        input  data_i, data_valid_i, fifo_data_ready_i,
        output data_ready_o, fifo_data_o, fifo_data_valid_o
    );

    modport master (
        output data_i, data_valid_i, fifo_data_ready_i,
        input  data_ready_o, fifo_data_o, fifo_data_valid_o
    );
endinterface

// File: rtl/i2s_tx_dsp_unpack.sv
// Unpacks 32-bit uDMA words into one or two sign/zero-extended samples and
// queues them in a small FIFO for the DSP channel.
module i2s_tx_dsp_unpack #(
    parameter int DEPTH = 4
) (
    input  logic                  sck_i,
    input  logic                  rstn_i,
    input  logic                  cfg_en_i,
    input  logic [4:0]            cfg_num_bits_i,
    input  logic                  cfg_pack_i,
    input  logic                  cfg_sign_ext_i,
    i2s_tx_dsp_unpack_if.slave    bus,
    output logic                  fifo_err_o,
    output logic [4:0]            fifo_level_o
);
    localparam int         PW        = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_LVL = 5'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    level_q;
    logic [31:0]   hold_q;
    logic          hold_vld_q, half_q, started_q, err_q;

    logic          pack_eff, accept, push, pop, fill;
    logic [31:0]   src, sample;

    assign bus.data_ready_o      = cfg_en_i & ~hold_vld_q;
    assign bus.fifo_data_valid_o = (level_q != 5'd0);
    assign bus.fifo_data_o       = mem[rd_ptr_q];
    assign fifo_err_o            = err_q;
    assign fifo_level_o          = level_q;

    // Two samples per word only make sense when each fits in 16 bits.
    assign pack_eff = cfg_pack_i & ~cfg_num_bits_i[4];
    assign accept   = bus.data_valid_i & bus.data_ready_o;
    assign pop      = bus.fifo_data_valid_o & bus.fifo_data_ready_i;
    assign push     = hold_vld_q & ((level_q < DEPTH_LVL) | pop);

    assign src  = !pack_eff ? hold_q
                : half_q    ? {16'h0000, hold_q[31:16]}
                :             {16'h0000, hold_q[15:0]};
    assign fill = cfg_sign_ext_i & src[cfg_num_bits_i];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sample = src;
        for (int i = 0; i < 32; i++) begin
            if (5'(i) > cfg_num_bits_i) sample[i] = fill;
        end
    end

    // NOTE: storage is deliberately not reset; level/valid gate every read of it.
    always_ff @(posedge sck_i) begin
        if (push) mem[wr_ptr_q] <= sample;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge sck_i) begin
        if (!rstn_i || !cfg_en_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            hold_vld_q <= 1'b0;
            half_q     <= 1'b0;
            started_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= started_q & bus.fifo_data_ready_i & (level_q == 5'd0);

            if (pop) started_q <= 1'b1;

            if (accept) begin
                hold_q     <= bus.data_i;
                hold_vld_q <= 1'b1;
                half_q     <= 1'b0;
            end else if (push) begin
                if (pack_eff && !half_q) half_q     <= 1'b1;
                else                     hold_vld_q <= 1'b0;
            end

            // Pointer arithmetic wraps naturally because DEPTH is a power of two.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            case ({push, pop})
                2'b10:   level_q <= level_q + 5'd1;
                2'b01:   level_q <= level_q - 5'd1;
                default: level_q <= level_q;
            endcase
        end
    end
endmodule
